// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: command record, lock states, sizes.
package dmem_arb_pkg;
  localparam int WORD_W  = 8;
  localparam int OP_W    = 3;
  localparam int AW      = WORD_W - OP_W;
  localparam int NUM_REQ = 2;

  typedef logic req_id_t;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKED0  = 2'd1,
    LOCKED1  = 2'd2
  } lock_state_t;

  typedef struct packed {
    logic              valid;
    req_id_t           id;
    logic              we;
    logic [AW-1:0]     addr;
    logic [WORD_W-1:0] wdata;
  } cmd_t;

  function automatic logic [NUM_REQ-1:0] id2oh(req_id_t id);
    return id ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester/memory bundle of the data-memory arbiter; lock exists only with DMEM_ARB_LOCK_EN.
interface dmem_arbiter_if;
  import dmem_arb_pkg::*;

  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ-1:0]             we;
  logic [NUM_REQ-1:0][AW-1:0]     addr;
  logic [NUM_REQ-1:0][WORD_W-1:0] wdata;
  logic [NUM_REQ-1:0]             gnt;
  logic [NUM_REQ-1:0]             ack;
  logic [WORD_W-1:0]              rdata;
  logic [AW-1:0]                  Daddress;
  logic [WORD_W-1:0]              Wdata;
  logic                           WE;
  logic [WORD_W-1:0]              Mdata;
`ifdef DMEM_ARB_LOCK_EN
  logic [NUM_REQ-1:0]             lock;

  modport slave  (input  req, we, addr, wdata, Mdata, lock,
                  output gnt, ack, rdata, Daddress, Wdata, WE);
  modport master (output req, we, addr, wdata, Mdata, lock,
                  input  gnt, ack, rdata, Daddress, Wdata, WE);
`else
  modport slave  (input  req, we, addr, wdata, Mdata,
                  output gnt, ack, rdata, Daddress, Wdata, WE);
  modport master (output req, we, addr, wdata, Mdata,
                  input  gnt, ack, rdata, Daddress, Wdata, WE);
`endif
endinterface

// File: rtl/dmem_arbiter_rr.sv
// Combinational two-way round-robin grant; ptr names the requester favoured on a tie.
module rr_arbiter
  import dmem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] mask_i,
  input  req_id_t            ptr_i,
  output logic [NUM_REQ-1:0] gnt_o
);
  logic [NUM_REQ-1:0] elig;

  assign elig  = req_i & mask_i;
  assign gnt_o = (&elig) ? id2oh(ptr_i) : elig;
endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: RR grant, one registered command stage, registered ack/rdata.
// Define DMEM_ARB_LOCK_EN to add the lock port and the ownership-hold FSM.
module dmem_arbiter
  import dmem_arb_pkg::*;
(
  input  logic           clock,
  input  logic           n_reset,
  dmem_arbiter_if.slave  bus
);
  logic [NUM_REQ-1:0] gnt_raw, xfer, mask;
  req_id_t            ptr_q, xfer_id;
  cmd_t               cmd_q;
  logic [NUM_REQ-1:0] ack_q;
  logic [WORD_W-1:0]  rdata_q;

  rr_arbiter u_rr (
    .req_i  (bus.req),
    .mask_i (mask),
    .ptr_i  (ptr_q),
    .gnt_o  (gnt_raw)
  );

  // Grant is combinational, so it must be gated by reset explicitly.
  assign bus.gnt = gnt_raw & {NUM_REQ{n_reset}};
  assign xfer    = bus.req & bus.gnt;
  assign xfer_id = xfer[1];

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset)   ptr_q <= 1'b0;
    else if (|xfer) ptr_q <= ~xfer_id;
  end

`ifdef DMEM_ARB_LOCK_EN
  lock_state_t        lk_q;
  logic [NUM_REQ-1:0] mask_q;

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      lk_q   <= UNLOCKED;
      mask_q <= '1;
    end else begin
      case (lk_q)
        UNLOCKED:
          if (|xfer && bus.lock[xfer_id]) begin
            lk_q   <= xfer_id ? LOCKED1 : LOCKED0;
            mask_q <= id2oh(xfer_id);
          end
        LOCKED0:
          if (!bus.lock[0] && (xfer[0] || !bus.req[0])) begin
            lk_q   <= UNLOCKED;
            mask_q <= '1;
          end
        LOCKED1:
          if (!bus.lock[1] && (xfer[1] || !bus.req[1])) begin
            lk_q   <= UNLOCKED;
            mask_q <= '1;
          end
        default: begin
          lk_q   <= UNLOCKED;
          mask_q <= '1;
        end
      endcase
    end
  end

  assign mask = mask_q;
`else
  assign mask = '1;
`endif

  // Address/data fields only load on a transfer so the memory bus holds when idle.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      cmd_q <= '0;
    end else begin
      cmd_q.valid <= |xfer;
      if (|xfer) begin
        cmd_q.id    <= xfer_id;
        cmd_q.we    <= bus.we[xfer_id];
        cmd_q.addr  <= bus.addr[xfer_id];
        cmd_q.wdata <= bus.wdata[xfer_id];
      end
    end
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      ack_q   <= '0;
      rdata_q <= '0;
    end else begin
      ack_q <= cmd_q.valid ? id2oh(cmd_q.id) : '0;
      if (cmd_q.valid && !cmd_q.we) rdata_q <= bus.Mdata;
    end
  end

  assign bus.WE       = cmd_q.valid & cmd_q.we;
  assign bus.Daddress = cmd_q.addr;
  assign bus.Wdata    = cmd_q.wdata;
  assign bus.ack      = ack_q;
  assign bus.rdata    = rdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic clock   = 1'b0;
  logic n_reset = 1'b0;
  always #5 clock = ~clock;

  dmem_arbiter_if ifc();
  dmem_arbiter dut (.clock(clock), .n_reset(n_reset), .bus(ifc.slave));

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [WORD_W-1:0] mem  [2**AW];
  logic [WORD_W-1:0] mmem [2**AW];
  logic              mem_init = 1'b0;

  assign ifc.Mdata = mem[ifc.Daddress];

  typedef struct {
    int                c;
    int                id;
    logic              we;
    logic [AW-1:0]     addr;
    logic [WORD_W-1:0] wd;
    logic [WORD_W-1:0] rd;
  } txn_t;

  txn_t              txq[$];
  int                m_ptr     = 0;
  int                owner     = -1;
  logic [AW-1:0]     last_addr = '0;
  logic [WORD_W-1:0] last_wd   = '0;
  logic [1:0]        m_xfer    = '0;

  // Physical memory, model memory write commit, and cycle count.
  always @(posedge clock) begin
    if (!mem_init) begin
      for (int k = 0; k < 2**AW; k++) begin
        mem[k]  <= WORD_W'(k * 37 + 5);
        mmem[k]  = WORD_W'(k * 37 + 5);
      end
      mem_init <= 1'b1;
    end else if (ifc.WE) begin
      mem[ifc.Daddress] <= ifc.Wdata;
    end
    if (n_reset)
      foreach (txq[k])
        if (txq[k].c == cyc - 1 && txq[k].we) mmem[txq[k].addr] = txq[k].wd;
    cyc = cyc + 1;
  end

  // Transaction-level scoreboard: transfer in c, bus in c+1, ack in c+2.
  always @(negedge clock) begin
    logic [1:0]        e_gnt, e_ack, elig;
    logic              e_we, rd_chk;
    logic [WORD_W-1:0] e_rd;
    int                id;
    m_xfer = '0;
    if (!n_reset) begin
      txq.delete();
      m_ptr = 0; owner = -1; last_addr = '0; last_wd = '0;
    end else begin
      e_we = 1'b0; e_ack = '0; rd_chk = 1'b0; e_rd = '0;
      foreach (txq[k]) begin
        if (txq[k].c == cyc - 1) begin
          e_we      = txq[k].we;
          last_addr = txq[k].addr;
          last_wd   = txq[k].wd;
          txq[k].rd = mmem[txq[k].addr];
        end
        if (txq[k].c == cyc - 2) begin
          e_ack[txq[k].id] = 1'b1;
          if (!txq[k].we) begin rd_chk = 1'b1; e_rd = txq[k].rd; end
        end
      end
      while (txq.size() > 0 && txq[0].c <= cyc - 2) void'(txq.pop_front());
      n_chk++; if (ifc.WE !== e_we) begin n_fail++; $display("FAIL sb_WE cyc=%0d got=%b exp=%b", cyc, ifc.WE, e_we); end
      n_chk++; if (ifc.Daddress !== last_addr) begin n_fail++; $display("FAIL sb_Daddress cyc=%0d got=%h exp=%h", cyc, ifc.Daddress, last_addr); end
      n_chk++; if (ifc.Wdata !== last_wd) begin n_fail++; $display("FAIL sb_Wdata cyc=%0d got=%h exp=%h", cyc, ifc.Wdata, last_wd); end
      n_chk++; if (ifc.ack !== e_ack) begin n_fail++; $display("FAIL sb_ack cyc=%0d got=%b exp=%b", cyc, ifc.ack, e_ack); end
      if (rd_chk) begin
        n_chk++; if (ifc.rdata !== e_rd) begin n_fail++; $display("FAIL sb_rdata cyc=%0d got=%h exp=%h", cyc, ifc.rdata, e_rd); end
      end
      elig = ifc.req;
      if (owner >= 0) elig = ifc.req & (2'b01 << owner);
      e_gnt = (elig == 2'b11) ? ((m_ptr != 0) ? 2'b10 : 2'b01) : elig;
      n_chk++; if (ifc.gnt !== e_gnt) begin n_fail++; $display("FAIL sb_gnt cyc=%0d got=%b exp=%b", cyc, ifc.gnt, e_gnt); end
      id = e_gnt[1] ? 1 : 0;
      if (e_gnt != 2'b00) begin
        txq.push_back('{c: cyc, id: id, we: ifc.we[id], addr: ifc.addr[id], wd: ifc.wdata[id], rd: '0});
        m_ptr  = 1 - id;
        m_xfer = e_gnt;
      end
`ifdef DMEM_ARB_LOCK_EN
      if (owner < 0) begin
        if (e_gnt != 2'b00 && ifc.lock[id]) owner = id;
      end else if (!ifc.lock[owner] && (e_gnt[owner] || !ifc.req[owner])) begin
        owner = -1;
      end
`endif
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    ifc.req = '0;
    n_reset = 1'b0;
    repeat (2) tick();
    n_reset = 1'b1;
  endtask

  task automatic test_reset();
    ifc.req = '0; ifc.we = '0; ifc.addr = '0; ifc.wdata = '0;
`ifdef DMEM_ARB_LOCK_EN
    ifc.lock = '0;
`endif
    repeat (2) tick();
    ifc.req = 2'b11; #1;
    n_chk++; if (ifc.gnt !== 2'b00) begin n_fail++; $display("FAIL rst_gnt got=%b exp=00", ifc.gnt); end
    n_chk++; if (ifc.ack !== 2'b00) begin n_fail++; $display("FAIL rst_ack got=%b exp=00", ifc.ack); end
    n_chk++; if (ifc.rdata !== 8'h00) begin n_fail++; $display("FAIL rst_rdata got=%h exp=00", ifc.rdata); end
    n_chk++; if (ifc.Daddress !== 5'h00) begin n_fail++; $display("FAIL rst_Daddress got=%h exp=00", ifc.Daddress); end
    n_chk++; if (ifc.Wdata !== 8'h00) begin n_fail++; $display("FAIL rst_Wdata got=%h exp=00", ifc.Wdata); end
    n_chk++; if (ifc.WE !== 1'b0) begin n_fail++; $display("FAIL rst_WE got=%b exp=0", ifc.WE); end
    ifc.req = '0;
    n_reset = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    ifc.req = 2'b01; ifc.we = 2'b01; ifc.addr[0] = 5'h03; ifc.wdata[0] = 8'hA5; #1;
    n_chk++; if (ifc.gnt !== 2'b01) begin n_fail++; $display("FAIL wr_gnt got=%b exp=01", ifc.gnt); end
    tick(); ifc.req = '0; #1;
    n_chk++; if (ifc.WE !== 1'b1) begin n_fail++; $display("FAIL wr_WE got=%b exp=1", ifc.WE); end
    n_chk++; if (ifc.Daddress !== 5'h03) begin n_fail++; $display("FAIL wr_Daddress got=%h exp=03", ifc.Daddress); end
    n_chk++; if (ifc.Wdata !== 8'hA5) begin n_fail++; $display("FAIL wr_Wdata got=%h exp=a5", ifc.Wdata); end
    tick();
    n_chk++; if (ifc.ack !== 2'b01) begin n_fail++; $display("FAIL wr_ack got=%b exp=01", ifc.ack); end
    ifc.req = 2'b01; ifc.we = 2'b00; #1;
    n_chk++; if (ifc.gnt !== 2'b01) begin n_fail++; $display("FAIL rd_gnt got=%b exp=01", ifc.gnt); end
    tick(); ifc.req = '0;
    tick(); #1;
    n_chk++; if (ifc.ack !== 2'b01) begin n_fail++; $display("FAIL rd_ack got=%b exp=01", ifc.ack); end
    n_chk++; if (ifc.rdata !== 8'hA5) begin n_fail++; $display("FAIL rd_rdata got=%h exp=a5", ifc.rdata); end
    tick();
  endtask

  task automatic test_alternate();
    logic [1:0] hist [10];
    do_reset();
    ifc.req = 2'b11; ifc.we = 2'b00; ifc.addr[0] = 5'h03; ifc.addr[1] = 5'h1F;
    for (int i = 0; i < 10; i++) begin
      #1;
      hist[i] = (i % 2 == 1) ? 2'b10 : 2'b01;
      n_chk++; if (ifc.gnt !== hist[i]) begin n_fail++; $display("FAIL alt_gnt i=%0d got=%b exp=%b", i, ifc.gnt, hist[i]); end
      if (i >= 2) begin
        n_chk++; if (ifc.ack !== hist[i-2]) begin n_fail++; $display("FAIL alt_ack i=%0d got=%b exp=%b", i, ifc.ack, hist[i-2]); end
      end
      tick();
    end
    ifc.req = '0;
    repeat (2) tick();
  endtask

  task automatic test_raw();
    ifc.req = 2'b10; ifc.we = 2'b10; ifc.addr[1] = 5'h1F; ifc.wdata[1] = 8'h3C; #1;
    n_chk++; if (ifc.gnt !== 2'b10) begin n_fail++; $display("FAIL raw_gnt1 got=%b exp=10", ifc.gnt); end
    tick(); ifc.req = 2'b01; ifc.we = 2'b00; ifc.addr[0] = 5'h1F; #1;
    n_chk++; if (ifc.gnt !== 2'b01) begin n_fail++; $display("FAIL raw_gnt0 got=%b exp=01", ifc.gnt); end
    tick(); ifc.req = '0; #1;
    n_chk++; if (ifc.ack !== 2'b10) begin n_fail++; $display("FAIL raw_ack1 got=%b exp=10", ifc.ack); end
    tick(); #1;
    n_chk++; if (ifc.ack !== 2'b01) begin n_fail++; $display("FAIL raw_ack0 got=%b exp=01", ifc.ack); end
    n_chk++; if (ifc.rdata !== 8'h3C) begin n_fail++; $display("FAIL raw_rdata got=%h exp=3c", ifc.rdata); end
    tick();
  endtask

  task automatic test_single();
    ifc.req = 2'b10; ifc.we = 2'b00;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++; if (ifc.gnt !== 2'b10) begin n_fail++; $display("FAIL single_gnt i=%0d got=%b exp=10", i, ifc.gnt); end
      tick();
    end
    ifc.req = 2'b11; #1;
    n_chk++; if (ifc.gnt !== 2'b01) begin n_fail++; $display("FAIL single_r0 got=%b exp=01", ifc.gnt); end
    tick(); ifc.req = '0;
    repeat (2) tick();
  endtask

  task automatic test_reset_midflight();
    logic [WORD_W-1:0] old;
    old = mem[7];
    ifc.req = 2'b01; ifc.we = 2'b01; ifc.addr[0] = 5'h07; ifc.wdata[0] = ~old; #1;
    n_chk++; if (ifc.gnt !== 2'b01) begin n_fail++; $display("FAIL mrst_gnt got=%b exp=01", ifc.gnt); end
    tick(); ifc.req = '0; #1;
    n_chk++; if (ifc.WE !== 1'b1) begin n_fail++; $display("FAIL mrst_WE_pre got=%b exp=1", ifc.WE); end
    n_reset = 1'b0; #1;
    n_chk++; if (ifc.WE !== 1'b0) begin n_fail++; $display("FAIL mrst_WE got=%b exp=0", ifc.WE); end
    n_chk++; if (ifc.Daddress !== 5'h00) begin n_fail++; $display("FAIL mrst_Daddress got=%h exp=00", ifc.Daddress); end
    ifc.req = 2'b11; ifc.we = 2'b00; #1;
    n_chk++; if (ifc.gnt !== 2'b00) begin n_fail++; $display("FAIL mrst_gnt_low got=%b exp=00", ifc.gnt); end
    tick(); #1;
    n_chk++; if (ifc.ack !== 2'b00) begin n_fail++; $display("FAIL mrst_ack got=%b exp=00", ifc.ack); end
    n_chk++; if (ifc.Wdata !== 8'h00) begin n_fail++; $display("FAIL mrst_Wdata got=%h exp=00", ifc.Wdata); end
    n_chk++; if (ifc.rdata !== 8'h00) begin n_fail++; $display("FAIL mrst_rdata got=%h exp=00", ifc.rdata); end
    tick();
    n_chk++; if (mem[7] !== old) begin n_fail++; $display("FAIL mrst_mem07 got=%h exp=%h", mem[7], old); end
    n_reset = 1'b1; #1;
    n_chk++; if (ifc.gnt !== 2'b01) begin n_fail++; $display("FAIL mrst_first_gnt got=%b exp=01", ifc.gnt); end
    tick(); ifc.req = '0;
    repeat (2) tick();
  endtask

  task automatic test_lock();
    do_reset();
    ifc.req = 2'b10; ifc.we = 2'b00; ifc.addr[1] = 5'h10;
`ifdef DMEM_ARB_LOCK_EN
    ifc.lock = 2'b10;
`endif
    #1;
    n_chk++; if (ifc.gnt !== 2'b10) begin n_fail++; $display("FAIL lock_gnt_a got=%b exp=10", ifc.gnt); end
    tick(); ifc.req = 2'b01; ifc.addr[0] = 5'h10;
`ifdef DMEM_ARB_LOCK_EN
    #1;
    n_chk++; if (ifc.gnt !== 2'b00) begin n_fail++; $display("FAIL lock_stall got=%b exp=00", ifc.gnt); end
    tick(); ifc.req = 2'b11; ifc.we = 2'b10; ifc.wdata[1] = 8'h5A; ifc.lock = 2'b00; #1;
    n_chk++; if (ifc.gnt !== 2'b10) begin n_fail++; $display("FAIL lock_unlock got=%b exp=10", ifc.gnt); end
    tick(); ifc.req = 2'b01; ifc.we = 2'b00; #1;
    n_chk++; if (ifc.gnt !== 2'b01) begin n_fail++; $display("FAIL lock_after got=%b exp=01", ifc.gnt); end
`else
    #1;
    n_chk++; if (ifc.gnt !== 2'b01) begin n_fail++; $display("FAIL nolock_gnt_b got=%b exp=01", ifc.gnt); end
    tick(); ifc.req = 2'b10; ifc.we = 2'b10; ifc.wdata[1] = 8'h5A; #1;
    n_chk++; if (ifc.gnt !== 2'b10) begin n_fail++; $display("FAIL nolock_gnt_c got=%b exp=10", ifc.gnt); end
`endif
    tick(); ifc.req = '0; ifc.we = '0;
    repeat (2) tick();
  endtask

  task automatic test_random();
    logic [1:0] pend;
    pend = '0;
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < 2; i++) begin
        if (m_xfer[i]) pend[i] = 1'b0;
        if (!pend[i] && $urandom_range(3) != 0) begin
          pend[i]      = 1'b1;
          ifc.we[i]    = 1'($urandom_range(1));
          ifc.addr[i]  = ($urandom_range(1) != 0) ? AW'($urandom_range(3)) : AW'($urandom);
          ifc.wdata[i] = WORD_W'($urandom);
        end
      end
      ifc.req = pend;
`ifdef DMEM_ARB_LOCK_EN
      ifc.lock = {1'($urandom_range(3) == 0), 1'($urandom_range(3) == 0)};
`endif
      tick();
    end
    ifc.req = '0;
`ifdef DMEM_ARB_LOCK_EN
    ifc.lock = '0;
`endif
    repeat (3) tick();
    for (int k = 0; k < 2**AW; k++) begin
      n_chk++; if (mem[k] !== mmem[k]) begin n_fail++; $display("FAIL rnd_mem addr=%0d got=%h exp=%h", k, mem[k], mmem[k]); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write_read();
    test_alternate();
    test_raw();
    test_single();
    test_reset_midflight();
    test_lock();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
